// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its registered issue/retire stage.
//
// Contents:
//   alu_op_t       4-bit opcode enum (OP_ADD .. OP_SHR); codes 9..15 are illegal
//   OP_LAST        highest legal opcode
//   issue_state_t  state of the issue/retire FSM
//   is_illegal()   true for any opcode above OP_LAST

package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_NOT = 4'd6,
        OP_SHL = 4'd7,
        OP_SHR = 4'd8
    } alu_op_t;

    localparam logic [3:0] OP_LAST = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } issue_state_t;

    // Any encoding past the last defined opcode is rejected by the issue stage.
    function automatic logic is_illegal(input logic [3:0] op);
        return op > OP_LAST;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational N-bit ALU.
//
// Ports:
//   a, b    in  N  operands
//   op      in  4  opcode (alu_op_t encoding; 9..15 produce 0)
//   sgn     in  1  signed mode (only division depends on it)
//   result  out N  low N bits of the operation
//
// Division by zero yields 0 here so the output is never X. The issue stage
// replaces it with all-ones and raises its own flag.

module alu
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   op,
    input  logic         sgn,
    output logic [N-1:0] result
);

    localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};
    localparam logic [N:0]   N_VAL   = (N+1)'(N);

    logic         shift_oob;
    logic [N-1:0] quotient;

    // A shift distance of N or more moves every bit out, so the result is zero.
    assign shift_oob = {1'b0, b} >= N_VAL;

    // Division. The zero divisor is guarded so the operator never sees it.
    // Signed min / -1 overflows; the truncated answer is min itself, which is
    // forced explicitly rather than relying on the simulator's overflow behaviour.
    always_comb begin
        quotient = '0;
        if (b == '0) begin
            quotient = '0;
        end else if (sgn) begin
            if ((a == MIN_VAL) && (b == '1)) begin
                quotient = MIN_VAL;
            end else begin
                quotient = $signed(a) / $signed(b);
            end
        end else begin
            quotient = a / b;
        end
    end

    // Opcode decode. Add, sub and mul keep only the low N bits, which are the
    // same in signed and unsigned mode. Right shift is always logical.
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_MUL:  result = a * b;
            OP_DIV:  result = quotient;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_NOT:  result = ~a;
            OP_SHL:  result = shift_oob ? '0 : (a << b);
            OP_SHR:  result = shift_oob ? '0 : (a >> b);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Registered issue/retire stage around the combinational alu.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   in_valid / in_ready           request handshake
//   in_a, in_b, in_op, in_signed  request payload, sampled on the accept edge
//   out_valid / out_ready         result handshake
//   out_result                    result after div0 / illegal overrides
//   out_zero                      out_result == 0
//   out_div0                      division by zero
//   out_illegal                   opcode 9..15
//   op_count                      completed output handshakes, wraps
//
// One request takes two edges: the accept edge latches the operands (EXEC),
// the next edge captures the result (DONE). In DONE the retiring handshake
// and a new accept may share one edge.

module alu_issue
    import alu_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_a,
    input  logic [N-1:0]  in_b,
    input  logic [3:0]    in_op,
    input  logic          in_signed,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_result,
    output logic          out_zero,
    output logic          out_div0,
    output logic          out_illegal,
    output logic [CW-1:0] op_count
);

    issue_state_t state_q, state_d;

    logic [N-1:0] a_q, b_q;
    logic [3:0]   op_q;
    logic         sgn_q;

    logic [N-1:0] alu_result;
    logic [N-1:0] final_result;
    logic         div0_d;
    logic         illegal_d;
    logic         accept;
    logic         retire;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs. In DONE, in_ready follows out_ready so
    // a new request can be taken on the same edge the old result leaves.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    state_d = in_valid ? EXEC : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign accept = in_valid & in_ready;
    assign retire = out_valid & out_ready;

    // Operand latch, so the alu sees stable inputs for the whole EXEC cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            sgn_q <= 1'b0;
        end else if (accept) begin
            a_q   <= in_a;
            b_q   <= in_b;
            op_q  <= in_op;
            sgn_q <= in_signed;
        end
    end

    alu #(
        .N (N)
    ) u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .sgn    (sgn_q),
        .result (alu_result)
    );

    // Overrides on top of the raw alu result. An illegal opcode can never also
    // be a division, so the two flags are mutually exclusive.
    always_comb begin
        div0_d       = (op_q == OP_DIV) && (b_q == '0);
        illegal_d    = is_illegal(op_q);
        final_result = alu_result;
        if (illegal_d) begin
            final_result = '0;
        end else if (div0_d) begin
            final_result = '1;
        end
    end

    // Result capture on the EXEC edge. The registers are not touched again
    // until the next EXEC, so the outputs hold steady throughout DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_result  <= '0;
            out_zero    <= 1'b0;
            out_div0    <= 1'b0;
            out_illegal <= 1'b0;
        end else if (state_q == EXEC) begin
            out_result  <= final_result;
            out_zero    <= (final_result == '0);
            out_div0    <= div0_d;
            out_illegal <= illegal_d;
        end
    end

    // Completed-operation counter. It counts output handshakes, not accepts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (retire) begin
            op_count <= op_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model built on integer arithmetic.

module tb_alu_issue;

    localparam int N  = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_a;
    logic [N-1:0]  in_b;
    logic [3:0]    in_op;
    logic          in_signed;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_result;
    logic          out_zero;
    logic          out_div0;
    logic          out_illegal;
    logic [CW-1:0] op_count;

    int checks = 0;
    int passes = 0;
    bit checking = 1'b0;

    // Model: 0 = no op, 1 = op accepted and computing, 2 = result on offer.
    int            m_phase = 0;
    logic [CW-1:0] m_cnt = '0;
    logic [N-1:0]  m_res = '0;
    logic          m_d0 = 1'b0;
    logic          m_il = 1'b0;
    logic [N-1:0]  p_a = '0;
    logic [N-1:0]  p_b = '0;
    logic [3:0]    p_op = '0;
    logic          p_s = 1'b0;
    bit            m_retire;
    bit            m_accept;

    always #5 clk = ~clk;

    alu_issue #(
        .N  (N),
        .CW (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_op       (in_op),
        .in_signed   (in_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_zero    (out_zero),
        .out_div0    (out_div0),
        .out_illegal (out_illegal),
        .op_count    (op_count)
    );

    // Reference arithmetic: operands widened to int, result truncated to N bits.
    function automatic void ref_alu(input logic [7:0] a, input logic [7:0] b,
                                    input logic [3:0] op, input logic s,
                                    output logic [7:0] r, output logic d0,
                                    output logic il);
        int ia;
        int ib;
        ia = s ? int'($signed(a)) : int'(a);
        ib = s ? int'($signed(b)) : int'(b);
        r  = 8'd0;
        d0 = 1'b0;
        il = 1'b0;
        case (op)
            4'd0: r = 8'(ia + ib);
            4'd1: r = 8'(ia - ib);
            4'd2: r = 8'(ia * ib);
            4'd3: begin
                if (ib == 0) begin
                    r  = 8'hFF;
                    d0 = 1'b1;
                end else begin
                    r = 8'(ia / ib);
                end
            end
            4'd4: r = a & b;
            4'd5: r = a | b;
            4'd6: r = ~a;
            4'd7: r = (b >= 8'd8) ? 8'd0 : 8'(int'(a) * (1 << int'(b)));
            4'd8: r = (b >= 8'd8) ? 8'd0 : 8'(int'(a) / (1 << int'(b)));
            default: il = 1'b1;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] a,
                                 input logic [7:0] b, input logic [3:0] op,
                                 input logic s, input logic r);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        in_signed = s;
        out_ready = r;
    endtask

    task automatic applyIdle(input logic r);
        applyStimulus(1'b0, 8'($urandom), 8'($urandom), 4'($urandom),
                      1'($urandom), r);
    endtask

    // Starts and ends at a falling edge; returns with the result on offer.
    task automatic runOp(input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op, input logic s);
        #1 applyStimulus(1'b1, a, b, op, s, 1'b0);
        @(negedge clk);
        checkOutput("exec_in_ready", 32'(in_ready), 32'd0);
        checkOutput("exec_out_valid", 32'(out_valid), 32'd0);
        #1 applyIdle(1'b0);
        @(negedge clk);
        checkOutput("done_out_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic retireOp(input int exp_count);
        #1 applyIdle(1'b1);
        @(negedge clk);
        checkOutput("retire_count", 32'(op_count), 32'(exp_count));
        checkOutput("retire_idle", 32'(out_valid), 32'd0);
        #1 applyIdle(1'b0);
    endtask

    function automatic logic [7:0] randOperand();
        case ($urandom_range(0, 6))
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return 8'h80;
            3:       return 8'h7F;
            4:       return 8'($urandom_range(0, 10));
            default: return 8'($urandom);
        endcase
    endfunction

    // Behavioural model, advanced on every rising edge from the driven inputs.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0;
            m_cnt   = '0;
        end else begin
            m_retire = (m_phase == 2) && out_ready;
            m_accept = in_valid && ((m_phase == 0) || m_retire);
            if (m_retire) begin
                m_cnt = m_cnt + 1'b1;
            end
            if (m_phase == 1) begin
                ref_alu(p_a, p_b, p_op, p_s, m_res, m_d0, m_il);
                m_phase = 2;
            end else if (m_accept) begin
                p_a     = in_a;
                p_b     = in_b;
                p_op    = in_op;
                p_s     = in_signed;
                m_phase = 1;
            end else if (m_retire) begin
                m_phase = 0;
            end
        end
    end

    // Compare process: handshakes and count every cycle, payload while valid.
    always @(negedge clk) begin
        if (checking) begin
            checkOutput("cmp_in_ready", 32'(in_ready),
                        32'((m_phase == 0) || ((m_phase == 2) && out_ready)));
            checkOutput("cmp_out_valid", 32'(out_valid), 32'(m_phase == 2));
            checkOutput("cmp_op_count", 32'(op_count), 32'(m_cnt));
            if (m_phase == 2) begin
                checkOutput("cmp_result", 32'(out_result), 32'(m_res));
                checkOutput("cmp_zero", 32'(out_zero), 32'(m_res == 8'd0));
                checkOutput("cmp_div0", 32'(out_div0), 32'(m_d0));
                checkOutput("cmp_illegal", 32'(out_illegal), 32'(m_il));
            end
        end
    end

    initial begin
        logic [7:0] r;
        logic       d0;
        logic       il;

        // Pin the reference model to hand-computed values.
        ref_alu(8'd200, 8'd100, 4'd0, 1'b0, r, d0, il);
        checkOutput("ref_add_wrap", 32'(r), 32'h2C);
        ref_alu(8'hF6, 8'h00, 4'd3, 1'b1, r, d0, il);
        checkOutput("ref_div0", 32'({r, d0, il}), 32'({8'hFF, 1'b1, 1'b0}));
        ref_alu(8'h80, 8'hFF, 4'd3, 1'b1, r, d0, il);
        checkOutput("ref_min_div_m1", 32'(r), 32'h80);
        ref_alu(8'hF6, 8'h03, 4'd3, 1'b1, r, d0, il);
        checkOutput("ref_sdiv_trunc", 32'(r), 32'hFD);
        ref_alu(8'hC8, 8'h03, 4'd8, 1'b1, r, d0, il);
        checkOutput("ref_shr_logical", 32'(r), 32'h19);
        ref_alu(8'h01, 8'h09, 4'd7, 1'b0, r, d0, il);
        checkOutput("ref_shl_oob", 32'(r), 32'h00);

        // Reset.
        rst_n = 1'b0;
        applyIdle(1'b0);
        repeat (2) @(negedge clk);
        checking = 1'b1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_result", 32'(out_result), 32'd0);
        checkOutput("rst_flags", 32'({out_zero, out_div0, out_illegal}), 32'd0);
        checkOutput("rst_count", 32'(op_count), 32'd0);
        #1 rst_n = 1'b1;

        // Unsigned add with wrap.
        runOp(8'd200, 8'd100, 4'd0, 1'b0);
        checkOutput("add_result", 32'(out_result), 32'd44);
        checkOutput("add_zero", 32'(out_zero), 32'd0);
        checkOutput("add_count_before", 32'(op_count), 32'd0);
        retireOp(1);

        // Signed divide by zero.
        runOp(8'hF6, 8'h00, 4'd3, 1'b1);
        checkOutput("div0_result", 32'(out_result), 32'hFF);
        checkOutput("div0_flag", 32'(out_div0), 32'd1);
        checkOutput("div0_illegal", 32'(out_illegal), 32'd0);
        checkOutput("div0_zero", 32'(out_zero), 32'd0);
        retireOp(2);

        // Backpressure with a competing request that must not be taken.
        runOp(8'd5, 8'd5, 4'd1, 1'b0);
        #1 applyStimulus(1'b1, 8'hAA, 8'h55, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("bp_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_result", 32'(out_result), 32'd0);
            checkOutput("bp_zero", 32'(out_zero), 32'd1);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        end
        retireOp(3);

        // Back-to-back with out_ready held high.
        #1 applyStimulus(1'b1, 8'd16, 8'd17, 4'd2, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("b2b_exec_ready", 32'(in_ready), 32'd0);
        #1 applyStimulus(1'b1, 8'd1, 8'd9, 4'd7, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("b2b_mul_valid", 32'(out_valid), 32'd1);
        checkOutput("b2b_mul_result", 32'(out_result), 32'h10);
        checkOutput("b2b_done_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        checkOutput("b2b_gap_valid", 32'(out_valid), 32'd0);
        checkOutput("b2b_count_mul", 32'(op_count), 32'd4);
        #1 applyIdle(1'b1);
        @(negedge clk);
        checkOutput("b2b_shl_valid", 32'(out_valid), 32'd1);
        checkOutput("b2b_shl_result", 32'(out_result), 32'h00);
        checkOutput("b2b_shl_zero", 32'(out_zero), 32'd1);
        @(negedge clk);
        checkOutput("b2b_count_shl", 32'(op_count), 32'd5);
        #1 applyIdle(1'b0);

        // Illegal opcode, then a legal op clears the flag.
        runOp(8'h12, 8'h34, 4'hC, 1'b0);
        checkOutput("ill_result", 32'(out_result), 32'd0);
        checkOutput("ill_flag", 32'(out_illegal), 32'd1);
        retireOp(6);
        runOp(8'hFE, 8'h03, 4'd2, 1'b1);
        checkOutput("smul_result", 32'(out_result), 32'hFA);
        checkOutput("smul_illegal", 32'(out_illegal), 32'd0);
        retireOp(7);

        // Reset while an op is in EXEC: the op must vanish.
        #1 applyStimulus(1'b1, 8'd7, 8'd3, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        #1 begin
            rst_n = 1'b0;
            applyIdle(1'b1);
        end
        @(negedge clk);
        checkOutput("rexec_valid", 32'(out_valid), 32'd0);
        checkOutput("rexec_count", 32'(op_count), 32'd0);
        checkOutput("rexec_result", 32'(out_result), 32'd0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rexec_no_emit", 32'({out_valid, op_count}), 32'd0);
        end

        // Randomized traffic, checked by the compare process.
        for (int i = 0; i < 1000; i++) begin
            #1 begin
                rst_n = ($urandom_range(0, 149) != 0);
                applyStimulus($urandom_range(0, 99) < 70, randOperand(),
                              randOperand(),
                              ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 8))
                                                         : 4'($urandom_range(9, 15)),
                              1'($urandom), $urandom_range(0, 99) < 60);
            end
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Registered issue/retire stage wrapped around the combinational `alu`. It accepts one operation per valid/ready handshake and latches the operands so the ALU sees stable inputs. It captures the result with status flags and holds it on an output valid/ready channel until the consumer (register writeback) takes it. It is the sequential boundary between instruction decode upstream and writeback downstream.

## Interface
- `N`, default 8: operand and result width; passed to `alu`.
- `CW`, default 16: width of the completed-operation counter.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  stage can accept a request this cycle.
- `in_a`, `in_b`  in  N each  operands.
- `in_op`  in  4  opcode, same encoding as `alu` (0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 not-a, 7 shl, 8 shr).
- `in_signed`  in  1  signed mode.
- `out_valid`  out  1  result held for the consumer.
- `out_ready`  in  1  consumer accepts the result.
- `out_result`  out  N  result.
- `out_zero`  out  1  `out_result == 0`.
- `out_div0`  out  1  opcode 3 with `b == 0`.
- `out_illegal`  out  1  opcode 9–15.
- `op_count`  out  CW  number of completed output handshakes.

## Operation
- FSM has three states:
  - IDLE: `in_ready=1`, `out_valid=0`.
  - EXEC: operands are latched and the ALU evaluates; `in_ready=0`, `out_valid=0`.
  - DONE: `out_valid=1`, outputs held stable.
- Transitions:
  - IDLE→EXEC on `in_valid`; the edge latches `a`, `b`, `op`, `signed`.
  - EXEC→DONE unconditionally; the edge captures result and flags.
  - DONE with `out_ready=0`: stay in DONE; all outputs held bit-stable.
  - DONE with `out_ready=1`, `in_valid=0`: go to IDLE.
  - DONE with `out_ready=1`, `in_valid=1`: go to EXEC and latch the new request.
- `in_ready = (state==IDLE) | (state==DONE & out_ready)`, combinational from state and `out_ready`.
- Result rules (the stage overrides the `alu` output where noted):
  - Division by zero: `out_result = {N{1'b1}}`, `out_div0=1`. Never X.
  - Illegal opcode: `out_result = 0`, `out_illegal=1`.
  - Mul: low N bits of the product.
  - Signed `min/-1`: truncated, giving `min`, no flag.
  - Shifts by `b >= N` give 0; right shift is logical in both modes.
  - All other cases pass the `alu` result through unchanged.
- `out_zero` is computed from the final (overridden) `out_result`.
- `op_count` increments on each `out_valid & out_ready` edge; wraps from all-ones to 0.

## Timing
- Reset: `rst_n=0` at a rising edge forces IDLE, clears `out_result`, all flags and `op_count` to 0, and discards any in-flight op. Takes priority over all handshakes.
- Latency: request accepted at edge k → `out_valid=1` after edge k+1.
- Throughput: one op per 2 cycles when `out_ready` is held high; no bubble beyond EXEC.
- Output channel: once `out_valid` rises, it stays high and the data stays unchanged until the handshake edge.
- Input channel: `in_*` values are sampled only on an edge where `in_valid & in_ready`; they are don't-care otherwise.
- A simultaneous output handshake and input accept in DONE counts the retiring op and launches the new one on the same edge.

## Structure
- Shared package `alu_pkg` holds:
  - typedef `alu_op_t` (4-bit enum: `OP_ADD` … `OP_SHR`);
  - constant `OP_LAST = 4'd8`;
  - the state enum `issue_state_t {IDLE, EXEC, DONE}`.
- One sub-module: an instance of `alu` (param N) fed from the operand registers. Div0 and illegal overrides live in `alu_issue`.

## Test plan
- Reset then unsigned add: N=8, a=8'd200, b=8'd100, op 0, accept at edge 1 → `out_valid` after edge 2, result 8'd44, zero=0, `op_count` 0→1 on handshake.
- Signed div by zero: a=8'hF6, b=0, op 3, signed=1 → result 8'hFF, div0=1, illegal=0, zero=0.
- Backpressure: sub a=5, b=5; hold `out_ready=0` for 4 cycles → result 0, zero=1 held stable, `in_ready=0` throughout; release → one handshake, `op_count` +1.
- Back-to-back: `out_ready=1`, `in_valid=1` continuously with mul 8'd16×8'd17 then shl 1<<9 → results 8'h10 then 8'h00, one result every 2 cycles.
- Illegal opcode 4'hC → result 0, illegal=1. Then a signed mul 8'hFE×8'h03 → result 8'hFA, illegal cleared.
- Reset in EXEC: assert `rst_n=0` for one edge mid-op → IDLE, `out_valid=0`, `op_count=0`, no result ever emitted for that op.
